// File: rtl/openofdm_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : openofdm_tx_pkg
//  Purpose  : Shared types and constants for the openofdm_tx sample path:
//             controller state encoding, STF period, IQ packing.
//  Revision : 1.0  initial release
// ============================================================================
package openofdm_tx_pkg;

  // Controller state, explicitly one bit wide
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stf_state_e;

  // Samples per short-training-field period
  localparam int STF_PERIOD = 16;

  // One IQ component width; a sample packs I in the upper half, Q in the lower
  localparam int IQ_W     = 16;
  localparam int SAMPLE_W = 2 * IQ_W;

  typedef struct packed {
    logic [IQ_W-1:0] i;
    logic [IQ_W-1:0] q;
  } iq_sample_t;

  // Arithmetic shift right by one of a two's-complement component
  // (rounds toward negative infinity)
  function automatic logic [IQ_W-1:0] iq_asr1(input logic [IQ_W-1:0] c);
    return {c[IQ_W-1], c[IQ_W-1:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/stf_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : stf_sequencer_if
//  Purpose  : valid/ready sample stream from a preamble sequencer to the
//             TX sample mux. master = producer, slave = consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface stf_sequencer_if;
  import openofdm_tx_pkg::*;

  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;
  logic                sample_ready;
  logic                sample_last;

  modport master (
    output sample_out,
    output sample_valid,
    output sample_last,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    input  sample_last,
    output sample_ready
  );

endinterface
`default_nettype wire

// File: rtl/stf_iq_halve.sv
`default_nettype none
// ============================================================================
//  Module   : stf_iq_halve
//  Purpose  : Combinational half-amplitude window: each IQ component of a
//             packed sample is arithmetically shifted right by one.
//  Revision : 1.0  initial release
// ============================================================================
module stf_iq_halve
  import openofdm_tx_pkg::*;
(
  input  logic [SAMPLE_W-1:0] iq_in,
  output logic [SAMPLE_W-1:0] iq_out
);

  iq_sample_t w_in;
  iq_sample_t w_out;

  assign w_in = iq_in;

  // Halve I and Q independently, preserving sign
  always_comb begin
    w_out   = w_in;
    w_out.i = iq_asr1(w_in.i);
    w_out.q = iq_asr1(w_in.q);
  end

  assign iq_out = w_out;

endmodule
`default_nettype wire

// File: rtl/stf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stf_sequencer
//  Purpose  : Plays out the 802.11 legacy short training field by walking
//             the external 16-entry STF ROM NUM_REPS times and streaming the
//             words over valid/ready, optionally halving the first sample.
//  Revision : 1.0  initial release
// ============================================================================
module stf_sequencer
  import openofdm_tx_pkg::*;
#(
  parameter int NUM_REPS  = 10,    // legal range 1..15
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic                clk,
  input  logic                phy_tx_arestn,
  input  logic                start,
  input  logic                abort,
  output logic [3:0]          stf_rom_addr,
  input  logic [SAMPLE_W-1:0] stf_rom_dout,
  stf_sequencer_if.master     tx,
  output logic                busy,
  output logic                done
);

  // Total samples in one sequence; at most 240 so it fits the 8-bit index
  localparam logic [7:0] TOTAL    = 8'(NUM_REPS * STF_PERIOD);
  localparam logic [7:0] LAST_IDX = TOTAL - 8'd1;

  stf_state_e          state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic                w_accept;
  logic                w_load;
  logic [SAMPLE_W-1:0] w_first_word;

  // First word of the sequence, windowed or passed straight through
  if (WINDOW_EN) begin : g_window_on
    stf_iq_halve u_halve (
      .iq_in  (stf_rom_dout),
      .iq_out (w_first_word)
    );
  end else begin : g_window_off
    assign w_first_word = stf_rom_dout;
  end

  // Handshake events in RUN: downstream takes the held sample, or the
  // output slot is (or is about to be) free and ROM words remain
  assign w_accept = valid_q && tx.sample_ready;
  assign w_load   = (!valid_q || tx.sample_ready) && (idx_q < TOTAL);

  // State register
  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort wins; leave RUN once the last sample is taken
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)              state_d = RUN;
        RUN:     if (w_accept && last_q) state_d = IDLE;
        default:                         state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: the ROM address follows the index only while running
  always_comb begin
    busy         = (state_q == RUN);
    stf_rom_addr = (state_q == RUN) ? idx_q[3:0] : 4'd0;
  end

  // Sample slot, index and completion flag registers
  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      idx_q    <= 8'd0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  // Datapath: load word 0 on start, then stream the ROM under valid/ready;
  // sample_q only changes on a load so it stays put while stalled
  always_comb begin
    idx_d    = idx_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    if (abort) begin
      // Any in-flight sample is dropped, even one being accepted now
      idx_d   = 8'd0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d = 8'd0;
          if (start) begin
            sample_d = w_first_word;
            valid_d  = 1'b1;
            idx_d    = 8'd1;
            last_d   = (TOTAL == 8'd1);
          end
        end
        RUN: begin
          if (w_accept && last_q) begin
            idx_d   = 8'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else if (w_load) begin
            sample_d = stf_rom_dout;
            valid_d  = 1'b1;
            idx_d    = idx_q + 8'd1;
            last_d   = (idx_q == LAST_IDX);
          end else if (w_accept) begin
            valid_d = 1'b0;
          end
        end
        default: begin
          idx_d   = 8'd0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  assign tx.sample_out   = sample_q;
  assign tx.sample_valid = valid_q;
  assign tx.sample_last  = last_q;
  assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stf_sequencer
//  Purpose  : Directed self-checking bench for stf_sequencer. Two instances:
//             u_dut0 (NUM_REPS=10, window on), u_dut1 (NUM_REPS=1, window off),
//             each with its own combinational STF ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stf_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1, abort, ready;
  logic sel;

  logic [3:0]  addr0, addr1;
  logic [31:0] dout0, dout1;
  logic        busy0, busy1, done0, done1;

  logic [31:0] rom [16];
  logic [31:0] got [256];

  int n_cmp = 0;
  int n_err = 0;

  stf_sequencer_if if0 ();
  stf_sequencer_if if1 ();

  assign if0.sample_ready = ready;
  assign if1.sample_ready = ready;
  assign dout0 = rom[addr0];
  assign dout1 = rom[addr1];

  always #5 clk = ~clk;

  stf_sequencer #(.NUM_REPS(10), .WINDOW_EN(1'b1)) u_dut0 (
    .clk           (clk),
    .phy_tx_arestn (rst_n),
    .start         (start0),
    .abort         (abort),
    .stf_rom_addr  (addr0),
    .stf_rom_dout  (dout0),
    .tx            (if0),
    .busy          (busy0),
    .done          (done0)
  );

  stf_sequencer #(.NUM_REPS(1), .WINDOW_EN(1'b0)) u_dut1 (
    .clk           (clk),
    .phy_tx_arestn (rst_n),
    .start         (start1),
    .abort         (abort),
    .stf_rom_addr  (addr1),
    .stf_rom_dout  (dout1),
    .tx            (if1),
    .busy          (busy1),
    .done          (done1)
  );

  // Observed stream of the instance under test
  logic        valid_m, last_m, done_m, busy_m;
  logic [31:0] sample_m;
  always_comb begin
    valid_m  = sel ? if1.sample_valid : if0.sample_valid;
    last_m   = sel ? if1.sample_last  : if0.sample_last;
    sample_m = sel ? if1.sample_out   : if0.sample_out;
    done_m   = sel ? done1 : done0;
    busy_m   = sel ? busy1 : busy0;
  end

  initial begin
    rom[0]  = 32'h02f2_02f2; rom[1]  = 32'hfe68_03d9;
    rom[2]  = 32'hffd3_fb6a; rom[3]  = 32'h0567_ffe1;
    rom[4]  = 32'h05e4_0011; rom[5]  = 32'h0566_ffe2;
    rom[6]  = 32'hffd4_fb69; rom[7]  = 32'hfe67_03da;
    rom[8]  = 32'h02f1_02f3; rom[9]  = 32'h03da_fe67;
    rom[10] = 32'hfb69_ffd4; rom[11] = 32'hffe2_0566;
    rom[12] = 32'h0011_05e4; rom[13] = 32'hffe1_0567;
    rom[14] = 32'hfb6a_ffd3; rom[15] = 32'h03d9_fe68;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Expected beat k; beat 0 halved per component when windowing
  function automatic logic [31:0] gold(input int k, input bit win);
    logic [31:0] w;
    w = rom[k % 16];
    if (k == 0 && win) w = {w[31], w[31:17], w[15], w[15:1]};
    return w;
  endfunction

  // Start one sequence on the selected instance and consume it with random
  // readiness; optional abort at a beat, stray start at a beat, and a new
  // start in the done cycle. Called and sampled at negedges.
  task automatic run_seq(
    input  int rdy_pct, input int abort_at, input int start_at, input bit b2b,
    output int beats, output int errs, output int dones,
    output int end_cyc, output int done_cyc,
    output logic v_after, output logic lat_v,
    output logic b2b_v, output logic [31:0] b2b_s, output logic busy_at_done);
    int total, post, r, b2b_pend;
    bit win, ended, stall_prev, stray_done;
    logic [31:0] prev_s;
    total = sel ? 16 : 160;
    win   = !sel;
    beats = 0; errs = 0; dones = 0; end_cyc = -1; done_cyc = -1;
    v_after = 1'bx; lat_v = 1'b0; b2b_v = 1'b0; b2b_s = '0; busy_at_done = 1'bx;
    post = 0; b2b_pend = 0; ended = 0; stall_prev = 0; stray_done = 0; prev_s = '0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
      if (cyc == 0) lat_v = valid_m;
      if (b2b_pend == 1) begin b2b_v = valid_m; b2b_s = sample_m; b2b_pend = 2; end
      if (stall_prev && (!valid_m || sample_m !== prev_s)) errs++;
      if (done_m) begin
        dones++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy_m; end
        if (b2b && b2b_pend == 0) begin
          if (sel) start1 = 1'b1; else start0 = 1'b1;
          b2b_pend = 1;
        end
      end
      if (ended && cyc == end_cyc + 1) v_after = valid_m;
      if (ended) begin post++; if (post > 4) break; end
      r = ($urandom_range(99) < rdy_pct) ? 1 : 0;
      ready = (r != 0);
      if (!ended && !stray_done && start_at >= 0 && beats == start_at && valid_m) begin
        start0 = !sel; start1 = sel; stray_done = 1;
      end
      if (!ended && valid_m && r != 0) begin
        if (abort_at >= 0 && beats == abort_at) begin
          abort = 1'b1; ended = 1; end_cyc = cyc;
        end else begin
          got[beats & 255] = sample_m;
          if (sample_m !== gold(beats, win)) errs++;
          if (last_m !== (beats == total - 1)) errs++;
          beats++;
          if (last_m || beats >= total) begin ended = 1; end_cyc = cyc; end
        end
      end
      stall_prev = valid_m && (r == 0);
      prev_s = sample_m;
      @(negedge clk);
    end
    abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
    if (!ended) errs++;
  endtask

  int beats, errs, dones, end_cyc, done_cyc;
  logic v_after, lat_v, b2b_v, busy_at_done;
  logic [31:0] b2b_s;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sample", if0.sample_out, 32'h0);
    check_eq("rst_flags", {27'd0, if0.sample_valid, if0.sample_last, busy0, done0, |addr0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_flags", {28'd0, if0.sample_valid, if0.sample_last, busy0, done0}, 32'h0);
    check_eq("idle_addr", {28'd0, addr0}, 32'h0);

    // Full-throughput sequence, NUM_REPS=10 with window
    run_seq(100, -1, -1, 1'b0, beats, errs, dones, end_cyc, done_cyc, v_after, lat_v, b2b_v, b2b_s, busy_at_done);
    check_eq("full_beats", beats, 160);
    check_eq("full_errs", errs, 0);
    check_eq("full_latency", {31'd0, lat_v}, 32'd1);
    check_eq("full_last_cyc", end_cyc, 159);
    check_eq("full_done_delay", done_cyc - end_cyc, 1);
    check_eq("full_done_count", dones, 1);
    check_eq("full_busy_at_done", {31'd0, busy_at_done}, 32'd0);
    check_eq("beat0", got[0], 32'h0179_0179);
    check_eq("beat1", got[1], 32'hfe68_03d9);
    check_eq("beat16", got[16], 32'h02f2_02f2);
    check_eq("beat159", got[159], 32'h03d9_fe68);

    // Random backpressure
    run_seq(50, -1, -1, 1'b0, beats, errs, dones, end_cyc, done_cyc, v_after, lat_v, b2b_v, b2b_s, busy_at_done);
    check_eq("bp_beats", beats, 160);
    check_eq("bp_errs", errs, 0);
    check_eq("bp_done_count", dones, 1);
    check_eq("bp_done_delay", done_cyc - end_cyc, 1);

    // Abort while beat 37 is being accepted
    run_seq(100, 37, -1, 1'b0, beats, errs, dones, end_cyc, done_cyc, v_after, lat_v, b2b_v, b2b_s, busy_at_done);
    check_eq("abort_beats", beats, 37);
    check_eq("abort_errs", errs, 0);
    check_eq("abort_no_done", dones, 0);
    check_eq("abort_valid_after", {31'd0, v_after}, 32'd0);
    check_eq("abort_busy", {31'd0, busy0}, 32'd0);
    run_seq(100, -1, -1, 1'b0, beats, errs, dones, end_cyc, done_cyc, v_after, lat_v, b2b_v, b2b_s, busy_at_done);
    check_eq("restart_beat0", got[0], 32'h0179_0179);
    check_eq("restart_beats", beats, 160);

    // start && abort together in IDLE
    start0 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort = 1'b0;
    check_eq("start_abort_valid", {31'd0, if0.sample_valid}, 32'd0);
    check_eq("start_abort_busy", {31'd0, busy0}, 32'd0);

    // Stray start during RUN
    run_seq(100, -1, 50, 1'b0, beats, errs, dones, end_cyc, done_cyc, v_after, lat_v, b2b_v, b2b_s, busy_at_done);
    check_eq("stray_start_beats", beats, 160);
    check_eq("stray_start_errs", errs, 0);
    check_eq("stray_start_dones", dones, 1);

    // NUM_REPS=1, no window, back-to-back start in the done cycle
    sel = 1'b1;
    run_seq(100, -1, -1, 1'b1, beats, errs, dones, end_cyc, done_cyc, v_after, lat_v, b2b_v, b2b_s, busy_at_done);
    check_eq("r1_beats", beats, 16);
    check_eq("r1_errs", errs, 0);
    check_eq("r1_beat0", got[0], 32'h02f2_02f2);
    check_eq("r1_done_delay", done_cyc - end_cyc, 1);
    check_eq("r1_b2b_valid", {31'd0, b2b_v}, 32'd1);
    check_eq("r1_b2b_sample", b2b_s, 32'h02f2_02f2);
    ready = 1'b1;
    repeat (24) @(negedge clk);
    check_eq("r1_drained", {31'd0, busy1}, 32'd0);
    sel = 1'b0;

    // Asynchronous reset mid-sequence
    ready = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_sample", if0.sample_out, 32'h0);
    check_eq("arst_flags", {27'd0, if0.sample_valid, if0.sample_last, busy0, done0, |addr0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", {30'd0, busy0, if0.sample_valid}, 32'h0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check_eq("post_rst_valid", {31'd0, if0.sample_valid}, 32'd1);
    check_eq("post_rst_beat0", if0.sample_out, 32'h0179_0179);
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
